mem_access: RTL
===============

// Module: mem_access
// PURPOSE
//  MEM-stage data-memory access unit. Sits directly downstream of the EX/MEM pipeline register and feeds MEM/WB.
//  Turns the registered load/store request into a data-bus transaction with a req/ack handshake.
//  Performs byte-lane steering, load sign/zero extension and alignment/bus-error detection.
//  Raises stall_req while a transaction is outstanding.
// PARAMETERS
//  TIMEOUT_CYCLES  256  cycles in REQ without bus_ack before a data bus error is raised (>=2)
// PORTS
//  clk            in   1   clock, rising edge
//  rst            in   1   reset, asynchronous, active-high
//  mem_ce         in   1   memory access valid (from EX/MEM)
//  mem_we         in   1   1=store, 0=load
//  mem_addr       in   32  byte address
//  mem_wdata      in   32  store data, right-aligned
//  mem_size       in   2   00=byte 01=half 10=word (11 treated as word)
//  mem_signed     in   1   load sign-extends when 1
//  mem_reg_we     in   1   GPR write enable (from EX/MEM)
//  mem_reg_waddr  in   5   GPR write address
//  mem_reg_wdata  in   32  GPR write data for non-loads
//  mem_exc_in     in   1   exception already pending upstream
//  mem_exc_code_in in  5   its ExcCode
//  flush          in   1   pipeline flush
//  hold           in   1   downstream stall; freezes DONE
//  bus_req        out  1   transaction request (registered)
//  bus_we         out  1   write strobe (registered)
//  bus_addr       out  32  word-aligned address {addr[31:2],2'b00} (registered)
//  bus_be         out  4   byte enables (registered)
//  bus_wdata      out  32  lane-replicated store data (registered)
//  bus_ack        in   1   one-cycle pulse; ends transaction, bus_rdata valid same cycle
//  bus_rdata      in   32  read data
//  stall_req      out  1   stall request to pipeline controller (combinational)
//  wb_reg_we      out  1   to MEM/WB; forced 0 when exception or stall_req
//  wb_reg_waddr   out  5   to MEM/WB
//  wb_reg_wdata   out  32  extended load data (load in DONE), else mem_reg_wdata
//  wb_exc         out  1   exception occurred
//  wb_exc_code    out  5   ExcCode: upstream code, 4=AdEL, 5=AdES, 7=DBE
//  wb_badvaddr    out  32  mem_addr on AdEL/AdES, else 0
// BEHAVIOUR
//  Reset (async):
//   - state=IDLE; bus_req, bus_we = 0; bus_addr, bus_be, bus_wdata = 0.
//   - Timeout counter, load buffer and DBE flag = 0.
//  Misaligned: half with addr[0]!=0; word with addr[1:0]!=0.
//   - Sets wb_exc and AdEL/AdES combinationally; no bus transaction.
//   - Upstream mem_exc_in takes priority; its code passes through, no access.
//  acc = mem_ce & ~mem_exc_in & ~misaligned & ~flush.
//  Lanes, little-endian, off=addr[1:0]:
//   - byte: be=1<<off, wdata={4{wdata[7:0]}}.
//   - half: be=3<<off, wdata={2{wdata[15:0]}}.
//   - word: be=4'hF.
//   - Load extracts the same lane and extends per mem_signed.
//  FSM {IDLE, REQ, DONE, DRAIN}:
//   IDLE : stall_req=acc. If acc: register bus outputs, bus_req<=1, counter<=0, ->REQ.
//          Minimum load/store latency: 3 cycles from mem_ce to DONE (ack in first REQ cycle).
//   REQ  : stall_req=1; bus_* held stable.
//          - bus_ack: bus_req<=0, load_buf<=bus_rdata, ->DONE (ack wins over flush/timeout same cycle).
//          - flush without ack: ->DRAIN.
//          - counter==TIMEOUT_CYCLES-1 without ack: bus_req<=0, DBE flag<=1, ->DONE.
//          - else counter++.
//   DONE : stall_req=0; wb outputs from load_buf/DBE flag (DBE: wb_exc=1, code 7, reg_we=0).
//          - flush or ~hold: ->IDLE, clear DBE flag.
//          - hold: stay.
//          Request is not reissued while in DONE.
//   DRAIN: stall_req=1; bus_req stays 1 until bus_ack, then bus_req<=0, discard data, ->IDLE.
//          Timeout also exits to IDLE, no exception.
//  Stores complete only on ack; a store in REQ cannot be cancelled once issued.
//  wb_* outputs are combinational from inputs/state; consumers sample them only when stall_req=0.
// TESTING
//  1. LW addr 0x100, ack 3 cycles after bus_req with rdata 0xDEADBEEF:
//     -> bus_be=F; stall_req high 4 cycles; DONE gives wb_reg_wdata=0xDEADBEEF, wb_reg_we=1.
//  2. LB signed addr 0x103, rdata 0x80000000 -> 0xFFFFFF80; LBU -> 0x00000080; bus_be=4'b1000.
//  3. SH addr 0x201 -> bus_req never rises, wb_exc=1, code 5, badvaddr 0x201, wb_reg_we=0.
//     SH addr 0x202 data 0x1234 -> be=4'b1100, bus_wdata=0x12341234.
//  4. TIMEOUT_CYCLES=8, no ack -> bus_req high exactly 8 cycles, then DONE with wb_exc=1, code 7.
//  5. flush in 2nd REQ cycle, ack 3 cycles later -> DRAIN keeps bus_req and stall_req until ack;
//     IDLE next; no wb write.
//  6. hold=1 for 2 cycles in DONE -> outputs stable, no new bus_req.
//     Also: async rst mid-REQ -> bus_req=0 immediately, state IDLE.

Source files
------------

// File: rtl/mem_access.sv
// rtl/mem_access.sv - MEM-stage data-memory access unit
//
// Turns the registered EX/MEM load/store request into a req/ack data-bus
// transaction. It steers byte lanes and extends load data, and it detects
// misaligned and timed-out (DBE) accesses. stall_req is raised while a
// transaction is outstanding.
//
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   mem_*                 request fields from EX/MEM (held stable while stalled)
//   flush, hold           pipeline flush / downstream stall
//   bus_req..bus_wdata    registered bus request
//   bus_ack, bus_rdata    bus completion pulse and read data
//   stall_req             combinational stall request
//   wb_*                  combinational results toward MEM/WB
`timescale 1ns/1ps

module mem_access #(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_ce,
    input  logic        mem_we,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [1:0]  mem_size,
    input  logic        mem_signed,
    input  logic        mem_reg_we,
    input  logic [4:0]  mem_reg_waddr,
    input  logic [31:0] mem_reg_wdata,
    input  logic        mem_exc_in,
    input  logic [4:0]  mem_exc_code_in,
    input  logic        flush,
    input  logic        hold,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata,
    output logic        stall_req,
    output logic        wb_reg_we,
    output logic [4:0]  wb_reg_waddr,
    output logic [31:0] wb_reg_wdata,
    output logic        wb_exc,
    output logic [4:0]  wb_exc_code,
    output logic [31:0] wb_badvaddr
);

    localparam int                CNT_W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_DBE  = 5'd7;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_DONE  = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic               bus_req_q, bus_req_d;
    logic               bus_we_q, bus_we_d;
    logic [31:0]        bus_addr_q, bus_addr_d;
    logic [3:0]         bus_be_q, bus_be_d;
    logic [31:0]        bus_wdata_q, bus_wdata_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        load_buf_q, load_buf_d;
    logic               dbe_q, dbe_d;

    logic [1:0]         off;
    logic               misaligned;
    logic               acc;
    logic [3:0]         lane_be;
    logic [31:0]        lane_wdata;
    logic [31:0]        load_shift;
    logic [31:0]        load_ext;
    logic               in_done;

    assign off        = mem_addr[1:0];
    assign misaligned = mem_ce & (((mem_size == 2'b01) & off[0]) |
                                  (mem_size[1] & (off != 2'b00)));
    assign acc        = mem_ce & ~mem_exc_in & ~misaligned & ~flush;
    assign in_done    = (state_q == S_DONE);

    // Store lane steering: data is replicated across lanes so the byte
    // enables alone select what the memory writes.
    always_comb begin
        lane_be    = 4'hF;
        lane_wdata = mem_wdata;
        case (mem_size)
            2'b00: begin
                lane_be    = 4'b0001 << off;
                lane_wdata = {4{mem_wdata[7:0]}};
            end
            2'b01: begin
                lane_be    = 4'b0011 << off;
                lane_wdata = {2{mem_wdata[15:0]}};
            end
            default: ;
        endcase
    end

    // Load extraction uses the still-held EX/MEM fields to pick the lane.
    assign load_shift = load_buf_q >> {off, 3'b000};

    always_comb begin
        load_ext = load_shift;
        case (mem_size)
            2'b00: load_ext = mem_signed ? {{24{load_shift[7]}}, load_shift[7:0]}
                                         : {24'h0, load_shift[7:0]};
            2'b01: load_ext = mem_signed ? {{16{load_shift[15]}}, load_shift[15:0]}
                                         : {16'h0, load_shift[15:0]};
            default: ;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        bus_req_d   = bus_req_q;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_be_d    = bus_be_q;
        bus_wdata_d = bus_wdata_q;
        cnt_d       = cnt_q;
        load_buf_d  = load_buf_q;
        dbe_d       = dbe_q;
        case (state_q)
            S_IDLE: begin
                if (acc) begin
                    bus_req_d   = 1'b1;
                    bus_we_d    = mem_we;
                    bus_addr_d  = {mem_addr[31:2], 2'b00};
                    bus_be_d    = lane_be;
                    bus_wdata_d = lane_wdata;
                    cnt_d       = '0;
                    state_d     = S_REQ;
                end
            end
            S_REQ: begin
                // An ack in the same cycle as flush or timeout still completes.
                if (bus_ack) begin
                    bus_req_d  = 1'b0;
                    load_buf_d = bus_rdata;
                    state_d    = S_DONE;
                end else if (flush) begin
                    // The issued request cannot be withdrawn; wait for its ack.
                    state_d = S_DRAIN;
                end else if (cnt_q == CNT_LAST) begin
                    bus_req_d = 1'b0;
                    dbe_d     = 1'b1;
                    state_d   = S_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DONE: begin
                if (flush || !hold) begin
                    dbe_d   = 1'b0;
                    state_d = S_IDLE;
                end
            end
            S_DRAIN: begin
                if (bus_ack || (cnt_q == CNT_LAST)) begin
                    bus_req_d = 1'b0;
                    state_d   = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_be_q    <= '0;
            bus_wdata_q <= '0;
            cnt_q       <= '0;
            load_buf_q  <= '0;
            dbe_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_be_q    <= bus_be_d;
            bus_wdata_q <= bus_wdata_d;
            cnt_q       <= cnt_d;
            load_buf_q  <= load_buf_d;
            dbe_q       <= dbe_d;
        end
    end

    assign bus_req   = bus_req_q;
    assign bus_we    = bus_we_q;
    assign bus_addr  = bus_addr_q;
    assign bus_be    = bus_be_q;
    assign bus_wdata = bus_wdata_q;

    always_comb begin
        case (state_q)
            S_IDLE:  stall_req = acc;
            S_DONE:  stall_req = 1'b0;
            default: stall_req = 1'b1;
        endcase
    end

    // Exception priority: upstream, then alignment, then bus timeout.
    always_comb begin
        wb_exc      = 1'b0;
        wb_exc_code = 5'd0;
        wb_badvaddr = 32'h0;
        if (mem_exc_in) begin
            wb_exc      = 1'b1;
            wb_exc_code = mem_exc_code_in;
        end else if (misaligned) begin
            wb_exc      = 1'b1;
            wb_exc_code = mem_we ? EXC_ADES : EXC_ADEL;
            wb_badvaddr = mem_addr;
        end else if (in_done && dbe_q) begin
            wb_exc      = 1'b1;
            wb_exc_code = EXC_DBE;
        end
    end

    assign wb_reg_we    = mem_reg_we & ~wb_exc & ~stall_req;
    assign wb_reg_waddr = mem_reg_waddr;
    assign wb_reg_wdata = (in_done && mem_ce && !mem_we) ? load_ext : mem_reg_wdata;

endmodule
